// File: rtl/ruido_sweep_pkg.sv
// Shared definitions for the noise bit-width sweep controller.
// Holds the FSM state encoding, register map offsets and field widths.
// No ports; imported by ruido_sweep_ctrl and ruido_settle_timer.
package ruido_sweep_pkg;

  localparam int NB_W     = 6;   // num_bits width
  localparam int SETTLE_W = 16;  // settle counter width
  localparam int CNT_W    = 16;  // completed-acquisition count width

  localparam logic [2:0] ADDR_CTRL     = 3'd0;
  localparam logic [2:0] ADDR_BITS_MIN = 3'd1;
  localparam logic [2:0] ADDR_BITS_MAX = 3'd2;
  localparam logic [2:0] ADDR_STEP     = 3'd3;
  localparam logic [2:0] ADDR_SETTLE   = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;
  localparam logic [2:0] ADDR_MANUAL   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_START,
    S_WAIT_ACQ,
    S_ADVANCE
  } state_t;

endpackage

// File: rtl/ruido_settle_timer.sv
// Settle down-counter: load has priority, enable decrements and holds at zero.
// Ports: clk/reset_n; load + load_val preset the count; enable decrements;
// zero is combinational (count == 0).
module ruido_settle_timer
  import ruido_sweep_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic [SETTLE_W-1:0] load_val,
  input  logic                enable,
  output logic                zero
);

  logic [SETTLE_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ruido_sweep_ctrl.sv
// Sweeps the noise datapath bit-width from BITS_MIN to BITS_MAX in STEP
// increments, settling and requesting one acquisition per width.
// Ports: register bus (address/chipselect/write_n/writedata/readdata),
// num_bits to datapath, acq_start/acq_done handshake, busy and irq status.
module ruido_sweep_ctrl
  import ruido_sweep_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [5:0]  num_bits,
  output logic        acq_start,
  input  logic        acq_done,
  output logic        busy,
  output logic        irq
);

  state_t state, state_nxt;

  logic                irq_en, loop_en;
  logic [NB_W-1:0]     bits_min, bits_max, step, manual;
  logic [SETTLE_W-1:0] settle_cyc;
  logic [NB_W-1:0]     nb_reg;
  logic [CNT_W-1:0]    acq_cnt;
  logic                done, err;
  logic                start_req;

  // FSM strobes
  logic tmr_load, tmr_en, settle_zero;
  logic nb_load_min, nb_load_sum;
  logic set_done, set_err, cnt_clr, cnt_inc;

  logic wr_en, wr_ctrl, wr_status, abort, start_set;
  logic [NB_W-1:0] step_eff;
  logic [NB_W:0]   sum;
  logic            unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
  assign wr_status = wr_en && (address == ADDR_STATUS);
  assign abort     = wr_ctrl & writedata[1];
  // START is captured only while idle; ABORT in the same write cancels it.
  assign start_set = wr_ctrl & writedata[0] & ~writedata[1] & (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign unused_wdata = ^writedata[31:16];

  // Sum carried in 7 bits so a step past 63 cannot wrap back into range.
  assign step_eff = (step == '0) ? NB_W'(1) : step;
  assign sum      = {1'b0, nb_reg} + {1'b0, step_eff};

  // While idle the datapath follows MANUAL directly, so MANUAL writes and
  // ABORT take effect without an extra register stage.
  assign num_bits = busy ? nb_reg : manual;

  ruido_settle_timer u_settle_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (settle_cyc),
    .enable   (tmr_en),
    .zero     (settle_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    nb_load_min = 1'b0;
    nb_load_sum = 1'b0;
    set_done    = 1'b0;
    set_err     = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    acq_start   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_req) begin
          if (bits_min <= bits_max) begin
            nb_load_min = 1'b1;
            tmr_load    = 1'b1;
            cnt_clr     = 1'b1;
            state_nxt   = S_SETTLE;
          end else begin
            set_err  = 1'b1;
            set_done = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (settle_zero) state_nxt = S_START;
        else             tmr_en    = 1'b1;
      end
      S_START: begin
        acq_start = 1'b1;
        state_nxt = S_WAIT_ACQ;
      end
      S_WAIT_ACQ: begin
        if (acq_done) begin
          cnt_inc   = 1'b1;
          state_nxt = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (sum <= {1'b0, bits_max}) begin
          nb_load_sum = 1'b1;
          tmr_load    = 1'b1;
          state_nxt   = S_SETTLE;
        end else if (loop_en) begin
          nb_load_min = 1'b1;
          tmr_load    = 1'b1;
          state_nxt   = S_SETTLE;
        end else begin
          set_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // ABORT overrides everything and must not touch DONE or the count.
    if (abort) begin
      state_nxt   = S_IDLE;
      tmr_load    = 1'b0;
      tmr_en      = 1'b0;
      nb_load_min = 1'b0;
      nb_load_sum = 1'b0;
      set_done    = 1'b0;
      set_err     = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
    end
  end

  // Configuration registers: sweep parameters are frozen while busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en     <= 1'b0;
      loop_en    <= 1'b0;
      bits_min   <= '0;
      bits_max   <= '0;
      step       <= NB_W'(1);
      settle_cyc <= '0;
      manual     <= '0;
      start_req  <= 1'b0;
    end else begin
      start_req <= start_set;
      if (wr_ctrl) begin
        irq_en  <= writedata[2];
        loop_en <= writedata[3];
      end
      if (wr_en && (address == ADDR_MANUAL)) manual <= writedata[NB_W-1:0];
      if (wr_en && !busy) begin
        case (address)
          ADDR_BITS_MIN: bits_min   <= writedata[NB_W-1:0];
          ADDR_BITS_MAX: bits_max   <= writedata[NB_W-1:0];
          ADDR_STEP:     step       <= writedata[NB_W-1:0];
          ADDR_SETTLE:   settle_cyc <= writedata[SETTLE_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Sweep datapath, status flags and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nb_reg  <= '0;
      acq_cnt <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (nb_load_min)      nb_reg <= bits_min;
      else if (nb_load_sum) nb_reg <= sum[NB_W-1:0];

      if (cnt_clr)                          acq_cnt <= '0;
      else if (cnt_inc && (acq_cnt != '1))  acq_cnt <= acq_cnt + 1'b1;

      // A set event wins over a simultaneous write-1-clear.
      done <= set_done | (done & ~(wr_status & writedata[1]));
      err  <= set_err  | (err  & ~(wr_status & writedata[2]));
      irq  <= (done | err) & irq_en;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:     readdata[3:2]          = {loop_en, irq_en};
      ADDR_BITS_MIN: readdata[NB_W-1:0]     = bits_min;
      ADDR_BITS_MAX: readdata[NB_W-1:0]     = bits_max;
      ADDR_STEP:     readdata[NB_W-1:0]     = step;
      ADDR_SETTLE:   readdata[SETTLE_W-1:0] = settle_cyc;
      ADDR_STATUS:   readdata = {acq_cnt, 2'b00, num_bits, 5'b00000, err, done, busy};
      ADDR_MANUAL:   readdata[NB_W-1:0]     = manual;
      default:       readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ruido_sweep_ctrl.sv
// Directed and randomized checks of the sweep controller against a
// sequence model built from the sweep rules (min, min+step, ... <= max).
// The bench answers acq_start pulses with acq_done after a chosen delay.
module tb_ruido_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [5:0]  num_bits;
  logic        acq_start;
  logic        acq_done = 1'b0;
  logic        busy;
  logic        irq;

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  int last_wr_edge = 0;

  int   pulse_edge_q[$];
  int   pulse_nb_q[$];
  int   chg_edge_q[$];
  logic [5:0] prev_nb = '0;
  bit   auto_ack = 1'b0;
  int   ack_delay = 1;
  int   ack_cnt = 0;
  bit   busy_seen = 1'b0;

  ruido_sweep_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .num_bits   (num_bits),
    .acq_start  (acq_start),
    .acq_done   (acq_done),
    .busy       (busy),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  // Acquisition responder and output monitor; cyc_cnt here is the edge
  // just before this falling edge.
  always @(negedge clk) begin
    if (acq_done) acq_done = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) acq_done = 1'b1;
    end
    if (acq_start === 1'b1) begin
      pulse_edge_q.push_back(cyc_cnt);
      pulse_nb_q.push_back(int'(num_bits));
      if (auto_ack) ack_cnt = ack_delay;
    end
    if (num_bits !== prev_nb) begin
      chg_edge_q.push_back(cyc_cnt);
      prev_nb = num_bits;
    end
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(int a, int d);
    address      = 3'(a);
    writedata    = 32'(d);
    chipselect   = 1'b1;
    write_n      = 1'b0;
    last_wr_edge = cyc_cnt + 1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(int a, output logic [31:0] d);
    address    = 3'(a);
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    tick(1);
    while (busy !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  task automatic clear_q();
    pulse_edge_q.delete();
    pulse_nb_q.delete();
    chg_edge_q.delete();
  endtask

  initial begin
    logic [31:0] rv;
    int exp_rst[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
    int k, n, bmin, bmax, bstep, bset, se, bad;
    int exp_q[$];

    // ---- reset values ----
    #2;
    chk("rst_num_bits", 32'(num_bits), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_acq_start", 32'(acq_start), 0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      rd(i, rv);
      chk($sformatf("rst_reg%0d", i), rv, exp_rst[i]);
    end

    // ---- basic sweep 4,7,10 with SETTLE=2 ----
    wr(6, 33);
    tick(1);
    clear_q();
    wr(1, 4); wr(2, 10); wr(3, 3); wr(4, 2);
    auto_ack  = 1'b1;
    ack_delay = 1;
    wr(0, 1);
    k = last_wr_edge;
    tick(1);
    chk("sw_first_nb", 32'(num_bits), 4);
    chk("sw_busy", 32'(busy), 1);
    wait_idle(200);
    chk("sw_pulses", pulse_nb_q.size(), 3);
    for (int i = 0; i < pulse_nb_q.size() && i < 3; i++)
      chk($sformatf("sw_nb%0d", i), pulse_nb_q[i], 4 + 3 * i);
    chk("sw_nb_change_edge", chg_edge_q.size() > 0 ? chg_edge_q[0] : -1, k + 1);
    chk("sw_first_pulse_edge", pulse_edge_q.size() > 0 ? pulse_edge_q[0] : -1, k + 4);
    for (int i = 0; i < pulse_edge_q.size() && i < 3 && i < chg_edge_q.size(); i++)
      chk($sformatf("sw_settle_gap%0d", i), pulse_edge_q[i] - chg_edge_q[i], 3);
    rd(5, rv);
    chk("sw_done", 32'(rv[1]), 1);
    chk("sw_err", 32'(rv[2]), 0);
    chk("sw_count", 32'(rv[31:16]), 3);
    chk("sw_status_nb", 32'(rv[13:8]), 33);
    chk("sw_idle_nb", 32'(num_bits), 33);

    // ---- single width at the top of range, sum overflows 6 bits ----
    wr(5, 6);
    rd(5, rv);
    chk("w1c_done", 32'(rv[1]), 0);
    clear_q();
    wr(1, 63); wr(2, 63); wr(3, 5); wr(4, 0);
    wr(0, 1);
    wait_idle(100);
    chk("top_pulses", pulse_nb_q.size(), 1);
    chk("top_nb", pulse_nb_q.size() > 0 ? pulse_nb_q[0] : -1, 63);
    rd(5, rv);
    chk("top_done", 32'(rv[1]), 1);
    chk("top_err", 32'(rv[2]), 0);
    chk("top_count", 32'(rv[31:16]), 1);

    // ---- MIN > MAX error, with a clear colliding with the set ----
    wr(5, 6);
    wr(0, 4);
    tick(2);
    chk("err_irq_clear", 32'(irq), 0);
    clear_q();
    wr(1, 9); wr(2, 3);
    busy_seen = 1'b0;
    wr(0, 5);
    wr(5, 6);
    tick(3);
    chk("err_busy_seen", 32'(busy_seen), 0);
    chk("err_pulses", pulse_nb_q.size(), 0);
    rd(5, rv);
    chk("err_err", 32'(rv[2]), 1);
    chk("err_done", 32'(rv[1]), 1);
    chk("err_irq", 32'(irq), 1);

    // ---- LOOP with STEP=0, ABORT in WAIT_ACQ, late acq_done ----
    wr(5, 6);
    wr(0, 8);
    wr(1, 0); wr(2, 1); wr(3, 0); wr(4, 1);
    clear_q();
    auto_ack = 1'b1;
    wr(0, 9);
    n = 0;
    while (pulse_nb_q.size() < 3 && n < 300) begin tick(1); n++; end
    auto_ack = 1'b0;
    while (pulse_nb_q.size() < 4 && n < 400) begin tick(1); n++; end
    chk("loop_reach4", pulse_nb_q.size(), 4);
    wr(0, 10);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_nb", 32'(num_bits), 33);
    ack_cnt = 1;
    tick(4);
    chk("abort_pulses", pulse_nb_q.size(), 4);
    for (int i = 0; i < pulse_nb_q.size() && i < 4; i++)
      chk($sformatf("loop_nb%0d", i), pulse_nb_q[i], i % 2);
    rd(5, rv);
    chk("abort_done", 32'(rv[1]), 0);
    chk("abort_count", 32'(rv[31:16]), 3);
    chk("abort_status_busy", 32'(rv[0]), 0);

    // ---- reset in SETTLE ----
    wr(6, 5);
    wr(0, 0);
    wr(1, 2); wr(2, 9); wr(3, 1); wr(4, 20);
    wr(0, 1);
    tick(3);
    chk("mid_busy", 32'(busy), 1);
    chk("mid_nb", 32'(num_bits), 2);
    reset_n = 1'b0;
    #1;
    chk("arst_nb", 32'(num_bits), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_irq", 32'(irq), 0);
    chk("arst_acq_start", 32'(acq_start), 0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    chk("post_rst_nb", 32'(num_bits), 0);
    rd(6, rv);
    chk("post_rst_manual", rv, 0);
    wr(1, 7);
    rd(1, rv);
    chk("post_rst_min_wr", rv, 7);

    // ---- randomized sweeps against the sequence model ----
    for (int it = 0; it < 8; it++) begin
      bad   = (it % 4 == 3) ? 1 : 0;
      bmin  = int'($urandom_range(0, 63));
      if (bad != 0) begin
        if (bmin == 0) bmin = 1;
        bmax = int'($urandom_range(0, bmin - 1));
      end else begin
        bmax = int'($urandom_range(bmin, 63));
      end
      bstep     = int'($urandom_range(0, 15));
      bset      = int'($urandom_range(0, 4));
      ack_delay = int'($urandom_range(1, 3));
      auto_ack  = 1'b1;
      exp_q.delete();
      if (bmin <= bmax) begin
        se = (bstep == 0) ? 1 : bstep;
        for (int v = bmin; v <= bmax; v += se) exp_q.push_back(v);
      end
      wr(5, 6);
      wr(1, bmin); wr(2, bmax); wr(3, bstep); wr(4, bset);
      clear_q();
      wr(0, 1);
      k = last_wr_edge;
      if (bad != 0) tick(3);
      else          wait_idle(3000);
      chk($sformatf("rnd%0d_pulses", it), pulse_nb_q.size(), exp_q.size());
      for (int i = 0; i < pulse_nb_q.size() && i < exp_q.size(); i++)
        chk($sformatf("rnd%0d_nb%0d", it, i), pulse_nb_q[i], exp_q[i]);
      if (exp_q.size() > 0)
        chk($sformatf("rnd%0d_first_edge", it),
            pulse_edge_q.size() > 0 ? pulse_edge_q[0] : -1, k + 2 + bset);
      rd(5, rv);
      chk($sformatf("rnd%0d_done", it), 32'(rv[1]), 1);
      chk($sformatf("rnd%0d_err", it), 32'(rv[2]), bad);
      if (bad == 0)
        chk($sformatf("rnd%0d_count", it), 32'(rv[31:16]), exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
